// File: rtl/sales_recorder.sv
// sales_recorder: accumulates per-item sold counts and turnover from purchase records, rejecting bad or overflowing records
module sales_recorder #(
  parameter int SELL_W = 5,
  parameter int TURN_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [2:0]        rec_item,
  input  logic [2:0]        rec_qty,
  input  logic [TURN_W-1:0] rec_amount,
  input  logic              clr,
  output logic              rec_done,
  output logic              rec_err,
  output logic              ovf,
  output logic [SELL_W-1:0] sell1,
  output logic [SELL_W-1:0] sell2,
  output logic [SELL_W-1:0] sell3,
  output logic [SELL_W-1:0] sell4,
  output logic [SELL_W-1:0] sell5,
  output logic [SELL_W-1:0] sell6,
  output logic [SELL_W-1:0] sell7,
  output logic [TURN_W-1:0] turnover
);
  typedef enum logic [2:0] {IDLE, CHECK, COMMIT, DONE, ERR} state_t;
  state_t            state_q;
  logic [2:0]        item_q;
  logic [2:0]        qty_q;
  logic [TURN_W-1:0] amt_q;
  logic [TURN_W-1:0] turn_q;
  logic [SELL_W-1:0] sell_q [8];
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              ovf_q;
  logic [SELL_W:0]   sell_d;
  logic [TURN_W:0]   turn_d;
  // candidate new totals, one bit wider so the top bit flags overflow
  always_comb begin
    sell_d = {1'b0, sell_q[item_q]} + {{(SELL_W-2){1'b0}}, qty_q};
    turn_d = {1'b0, turn_q} + {1'b0, amt_q};
  end
  // record FSM; reset and manager clear share the same wipe, reset simply wins by being tested together
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= IDLE;
      item_q  <= '0;
      qty_q   <= '0;
      amt_q   <= '0;
      turn_q  <= '0;
      for (int i = 0; i < 8; i++) sell_q[i] <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rec_valid) begin
          item_q  <= rec_item;
          qty_q   <= rec_qty;
          amt_q   <= rec_amount;
          ready_q <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (item_q == 3'd0 || qty_q == 3'd0) begin
          err_q   <= 1'b1;
          state_q <= ERR;
        end else if (sell_d[SELL_W] || turn_d[TURN_W]) begin
          err_q   <= 1'b1;
          ovf_q   <= 1'b1;
          state_q <= ERR;
        end else begin
          state_q <= COMMIT;
        end
        COMMIT: begin
          sell_q[item_q] <= sell_d[SELL_W-1:0];
          turn_q         <= turn_d[TURN_W-1:0];
          done_q         <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign rec_ready = ready_q;
  assign rec_done  = done_q;
  assign rec_err   = err_q;
  assign ovf       = ovf_q;
  assign turnover  = turn_q;
  assign sell1     = sell_q[1];
  assign sell2     = sell_q[2];
  assign sell3     = sell_q[3];
  assign sell4     = sell_q[4];
  assign sell5     = sell_q[5];
  assign sell6     = sell_q[6];
  assign sell7     = sell_q[7];
endmodule
